// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the 4-port round-robin arbiter and its output mux.
// Port indices wrap modulo 4, which the 2-bit index type gives for free.
package rr_arb_pkg;

    localparam int N_PORTS = 4;

    typedef logic [1:0] port_idx_t;

    function automatic port_idx_t next_idx(input port_idx_t i);
        return i + 2'd1;
    endfunction

endpackage

// File: rtl/rr_grant_4.sv
// Combinational round-robin grant for four requesters.
// The search starts at the port after last_grant and wraps once around.
module rr_grant_4
    import rr_arb_pkg::*;
(
    input  logic [3:0] req,
    input  port_idx_t  last_grant,
    input  logic       en,
    output logic [3:0] grant_onehot,
    output port_idx_t  grant_idx,
    output logic       any_grant
);

    port_idx_t  cand [N_PORTS];
    logic [3:0] cand_req;

    // cand[0] is the highest-priority port, cand[3] is last_grant itself.
    genvar gi;
    generate
        for (gi = 0; gi < N_PORTS; gi++) begin : g_cand
            if (gi == 0) begin : g_first
                assign cand[gi] = next_idx(last_grant);
            end else begin : g_rest
                assign cand[gi] = next_idx(cand[gi-1]);
            end
            assign cand_req[gi] = req[cand[gi]];
        end
    endgenerate

    always_comb begin
        grant_onehot = 4'b0000;
        grant_idx    = 2'd0;
        any_grant    = 1'b0;
        if (en) begin
            for (int k = N_PORTS - 1; k >= 0; k--) begin
                if (cand_req[k]) begin
                    grant_idx = cand[k];
                    any_grant = 1'b1;
                end
            end
            if (any_grant) begin
                grant_onehot[grant_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arb_mux_4_1.sv
// Round-robin arbitration of four valid/ready producers into one registered
// output slot; the slot can drain and refill on the same edge.
module rr_arb_mux_4_1
    import rr_arb_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   in_valid,
    input  logic [W-1:0] in_data0,
    input  logic [W-1:0] in_data1,
    input  logic [W-1:0] in_data2,
    input  logic [W-1:0] in_data3,
    output logic [3:0]   in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic [1:0]   out_sel,
    input  logic         out_ready
);

    logic [W-1:0] data_arr [N_PORTS];
    port_idx_t    last_grant_reg;
    logic         out_valid_reg;
    logic [W-1:0] out_data_reg;
    port_idx_t    out_sel_reg;

    logic         load_en;
    logic [3:0]   grant_onehot;
    port_idx_t    grant_idx;
    logic         any_grant;

    assign data_arr[0] = in_data0;
    assign data_arr[1] = in_data1;
    assign data_arr[2] = in_data2;
    assign data_arr[3] = in_data3;

    assign load_en = !out_valid_reg || out_ready;

    // Grants are held off while reset is asserted so no handshake is lost.
    rr_grant_4 u_grant (
        .req          (in_valid),
        .last_grant   (last_grant_reg),
        .en           (load_en && rst),
        .grant_onehot (grant_onehot),
        .grant_idx    (grant_idx),
        .any_grant    (any_grant)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid_reg  <= 1'b0;
            out_data_reg   <= '0;
            out_sel_reg    <= 2'd0;
            last_grant_reg <= 2'd3;
        end else if (load_en) begin
            if (any_grant) begin
                out_valid_reg  <= 1'b1;
                out_data_reg   <= data_arr[grant_idx];
                out_sel_reg    <= grant_idx;
                last_grant_reg <= grant_idx;
            end else begin
                out_valid_reg  <= 1'b0;
            end
        end
    end

    assign in_ready  = grant_onehot;
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_sel   = out_sel_reg;

endmodule

// File: tb/tb_rr_arb_mux_4_1.sv
// Directed vector table plus a random valid/ready run checked against a
// reference round-robin model and an in-order scoreboard.
module tb_rr_arb_mux_4_1;

    logic       clk;
    logic       rst;
    logic [3:0] in_valid;
    logic [3:0] d [4];
    logic [3:0] in_ready;
    logic       out_valid;
    logic [3:0] out_data;
    logic [1:0] out_sel;
    logic       out_ready;

    int total;
    int bad;

    rr_arb_mux_4_1 #(.W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data0  (d[0]),
        .in_data1  (d[1]),
        .in_data2  (d[2]),
        .in_data3  (d[3]),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] v;
        logic [3:0] d1;
        logic [3:0] d3;
        logic       rdy;
        logic       chk_ir;
        logic [3:0] exp_ir;
        logic       exp_ov;
        logic [3:0] exp_od;
        logic [1:0] exp_os;
    } vec_t;

    typedef struct {
        logic [1:0] sel;
        logic [3:0] data;
    } item_t;

    vec_t  tbl [21];
    item_t sb [$];

    function automatic vec_t mkv(input logic r, input logic [3:0] v, input logic [3:0] d1,
                                 input logic [3:0] d3, input logic rdy, input logic chk,
                                 input logic [3:0] ir, input logic ov, input logic [3:0] od,
                                 input logic [1:0] os);
        vec_t t;
        t.rst = r; t.v = v; t.d1 = d1; t.d3 = d3; t.rdy = rdy; t.chk_ir = chk;
        t.exp_ir = ir; t.exp_ov = ov; t.exp_od = od; t.exp_os = os;
        return t;
    endfunction

    // Reference round-robin: first valid port after lg, wrapping.
    function automatic logic [3:0] rr_pick(input logic [1:0] lg, input logic [3:0] v);
        for (int k = 1; k <= 4; k++) begin
            int p;
            p = (int'(lg) + k) % 4;
            if (v[p]) return 4'(1 << p);
        end
        return 4'b0000;
    endfunction

    function automatic logic [1:0] onehot_idx(input logic [3:0] oh);
        for (int i = 0; i < 4; i++) if (oh[i]) return 2'(i);
        return 2'd0;
    endfunction

    task automatic check(input string name, input int idx, input logic [7:0] act,
                         input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] got=%h want=%h", name, idx, act, exp);
        end
    endtask

    initial begin
        logic [1:0] lg_m;
        logic [3:0] pend;
        logic [3:0] exp_ir;
        int         waitc [4];

        total = 0;
        bad   = 0;

        tbl[0]  = mkv(1, 4'b1111, 4'hB, 4'hD, 1, 1, 4'b0001, 1, 4'hA, 0);
        tbl[1]  = mkv(1, 4'b1111, 4'hB, 4'hD, 1, 1, 4'b0010, 1, 4'hB, 1);
        tbl[2]  = mkv(1, 4'b1111, 4'hB, 4'hD, 1, 1, 4'b0100, 1, 4'hC, 2);
        tbl[3]  = mkv(1, 4'b1111, 4'hB, 4'hD, 1, 1, 4'b1000, 1, 4'hD, 3);
        tbl[4]  = mkv(1, 4'b1111, 4'hB, 4'hD, 1, 1, 4'b0001, 1, 4'hA, 0);
        tbl[5]  = mkv(1, 4'b0101, 4'hB, 4'hD, 1, 1, 4'b0100, 1, 4'hC, 2);
        tbl[6]  = mkv(1, 4'b0101, 4'hB, 4'hD, 1, 1, 4'b0001, 1, 4'hA, 0);
        tbl[7]  = mkv(1, 4'b0101, 4'hB, 4'hD, 1, 1, 4'b0100, 1, 4'hC, 2);
        tbl[8]  = mkv(1, 4'b0101, 4'hB, 4'hD, 1, 1, 4'b0001, 1, 4'hA, 0);
        tbl[9]  = mkv(1, 4'b0010, 4'h5, 4'hD, 1, 1, 4'b0010, 1, 4'h5, 1);
        tbl[10] = mkv(1, 4'b1111, 4'h5, 4'hD, 0, 1, 4'b0000, 1, 4'h5, 1);
        tbl[11] = mkv(1, 4'b1111, 4'h5, 4'hD, 0, 1, 4'b0000, 1, 4'h5, 1);
        tbl[12] = mkv(1, 4'b1111, 4'h5, 4'hD, 0, 1, 4'b0000, 1, 4'h5, 1);
        tbl[13] = mkv(1, 4'b1111, 4'h5, 4'hD, 1, 1, 4'b0100, 1, 4'hC, 2);
        tbl[14] = mkv(1, 4'b1000, 4'h5, 4'hF, 1, 1, 4'b1000, 1, 4'hF, 3);
        tbl[15] = mkv(1, 4'b0000, 4'h5, 4'hF, 1, 1, 4'b0000, 0, 4'hF, 3);
        tbl[16] = mkv(1, 4'b0011, 4'hB, 4'hD, 1, 1, 4'b0001, 1, 4'hA, 0);
        tbl[17] = mkv(1, 4'b1110, 4'hB, 4'hD, 1, 1, 4'b0010, 1, 4'hB, 1);
        tbl[18] = mkv(0, 4'b1111, 4'hB, 4'hD, 0, 0, 4'b0000, 0, 4'h0, 0);
        tbl[19] = mkv(1, 4'b1111, 4'hB, 4'hD, 0, 1, 4'b0001, 1, 4'hA, 0);
        tbl[20] = mkv(1, 4'b1110, 4'hB, 4'hD, 1, 1, 4'b0010, 1, 4'hB, 1);

        rst = 1'b0; in_valid = 4'b0000; out_ready = 1'b1;
        d[0] = 4'hA; d[1] = 4'hB; d[2] = 4'hC; d[3] = 4'hD;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 0, 8'(out_valid), 8'h0);
        check("rst_out_data",  0, 8'(out_data),  8'h0);
        check("rst_out_sel",   0, 8'(out_sel),   8'h0);

        for (int i = 0; i < 21; i++) begin
            rst = tbl[i].rst; in_valid = tbl[i].v; out_ready = tbl[i].rdy;
            d[0] = 4'hA; d[1] = tbl[i].d1; d[2] = 4'hC; d[3] = tbl[i].d3;
            #1;
            if (tbl[i].chk_ir) check("vec_in_ready", i, 8'(in_ready), 8'(tbl[i].exp_ir));
            @(posedge clk);
            #1;
            check("vec_out_valid", i, 8'(out_valid), 8'(tbl[i].exp_ov));
            check("vec_out_data",  i, 8'(out_data),  8'(tbl[i].exp_od));
            check("vec_out_sel",   i, 8'(out_sel),   8'(tbl[i].exp_os));
            $display("vec %0d: v=%b rdy=%b -> in_ready=%b out=%b/%h/%0d",
                     i, tbl[i].v, tbl[i].rdy, in_ready, out_valid, out_data, out_sel);
        end

        // Random phase from a fresh reset so the model starts aligned.
        rst = 1'b0; in_valid = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        lg_m = 2'd3;
        pend = 4'b0000;
        for (int i = 0; i < 4; i++) waitc[i] = 0;
        sb.delete();

        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (!pend[i]) begin
                    pend[i] = ($urandom_range(0, 2) != 0);
                    d[i]    = 4'($urandom_range(0, 15));
                end
            end
            in_valid  = pend;
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            exp_ir = (!out_valid || out_ready) ? rr_pick(lg_m, in_valid) : 4'b0000;
            check("rnd_in_ready", c, 8'(in_ready), 8'(exp_ir));
            if (out_valid && out_ready) void'(sb.pop_front());
            if (exp_ir != 4'b0000) begin
                item_t it;
                it.sel  = onehot_idx(exp_ir);
                it.data = d[it.sel];
                sb.push_back(it);
                lg_m = it.sel;
                for (int i = 0; i < 4; i++) begin
                    if (exp_ir[i]) waitc[i] = 0;
                    else if (in_valid[i]) begin
                        waitc[i]++;
                        if (waitc[i] > 3) check("rnd_starve", i, 8'(waitc[i]), 8'd3);
                    end
                end
            end
            @(posedge clk);
            #1;
            pend = pend & ~exp_ir;
            check("rnd_out_valid", c, 8'(out_valid), 8'(sb.size() != 0));
            if (sb.size() != 0) begin
                check("rnd_out_word", c, {2'b00, out_sel, out_data}, {2'b00, sb[0].sel, sb[0].data});
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
